// File: rtl/sdr_16_responder.sv
// SDR SDRAM device-side responder for a 16-bit controller: init FSM, mode register, bank state, bursts, CL pipeline.
// Optional: define SDR16_RESP_AUTOPCH_EN to honour a[10] auto-precharge on RD/WR.
module sdr_16_responder #(
  parameter int ba_size      = 2,
  parameter int row_size     = 13,
  parameter int col_size     = 9,
  parameter int mem_row_bits = 2
) (
  input  logic                sdram_clk,
  input  logic                sdram_rst_n,
  input  logic [2:0]          cmd,
  input  logic [ba_size-1:0]  ba,
  input  logic [row_size-1:0] a,
  input  logic [1:0]          dqm,
  input  logic [15:0]         dq_i,
  output logic [15:0]         dq_o,
  output logic [1:0]          dq_oe_o,
  output logic                init_done,
  output logic                proto_err,
  output logic [2:0]          err_code,
  output logic [7:0]          aref_cnt
);
  localparam int NB    = 1 << ba_size;
  localparam int AW    = ba_size + mem_row_bits + col_size;
  localparam int DEPTH = 1 << AW;

  localparam logic [2:0] C_NOP  = 3'b111;
  localparam logic [2:0] C_ACT  = 3'b011;
  localparam logic [2:0] C_RD   = 3'b101;
  localparam logic [2:0] C_WR   = 3'b100;
  localparam logic [2:0] C_PCH  = 3'b010;
  localparam logic [2:0] C_AREF = 3'b001;
  localparam logic [2:0] C_LMR  = 3'b000;

  typedef enum logic [2:0] {I_PCH, I_RF1, I_RF2, I_LMR, READY} init_t;
  init_t istate;

  logic                    mode_cl3, mode_bt, mode_wb;
  logic [col_size-1:0]     mode_mask;
  logic [NB-1:0]           bank_open;
  logic [mem_row_bits-1:0] bank_row [NB];

  logic                    bst_act, bst_wr, bst_il, bst_ap;
  logic [ba_size-1:0]      bst_bank;
  logic [mem_row_bits-1:0] bst_row;
  logic [col_size-1:0]     bst_col, bst_mask, bst_cnt;

  logic [15:0] mem [DEPTH];
  logic        rd_vld_p0, rd_cl3_p0, rd_vld_p1;
  logic [15:0] rd_dat_p0, rd_dat_p1;
  logic [1:0]  dqm_p0;

  logic        err_hit, do_act, do_pch, do_aref, do_lmr, adv_init, new_burst, lmr_bad, pch_hit, cmd_ap;
  logic [2:0]  err_val;
  logic        beat_vld, beat_wr, beat_il, beat_ap, beat_last;
  logic [ba_size-1:0]      beat_bank;
  logic [mem_row_bits-1:0] beat_row;
  logic [col_size-1:0]     beat_base, beat_mask, beat_idx, beat_c;
  logic [AW-1:0]           beat_addr;
  logic        out_due;
  logic [1:0]  out_oe;
  logic [15:0] out_word;
  logic        unused_a_hi;

  assign unused_a_hi = ^a[row_size-1:11];

`ifdef SDR16_RESP_AUTOPCH_EN
  assign cmd_ap = a[10];
`else
  assign cmd_ap = 1'b0;
`endif

  // Burst length is a power of two, so its wrap mask is simply length-1.
  function automatic logic [col_size-1:0] bl_mask(input logic [2:0] code);
    case (code)
      3'b001:  return col_size'(1);
      3'b010:  return col_size'(3);
      3'b011:  return col_size'(7);
      3'b111:  return '1;
      default: return '0;
    endcase
  endfunction

  function automatic logic [col_size-1:0] beat_col(input logic [col_size-1:0] base,
                                                    input logic [col_size-1:0] mask,
                                                    input logic [col_size-1:0] idx,
                                                    input logic                il);
    logic [col_size-1:0] low;
    low = il ? (base ^ idx) : (base + idx);
    return (base & ~mask) | (low & mask);
  endfunction

  always_comb begin
    err_hit   = 1'b0;
    err_val   = 3'd0;
    do_act    = 1'b0;
    do_pch    = 1'b0;
    do_aref   = 1'b0;
    do_lmr    = 1'b0;
    adv_init  = 1'b0;
    new_burst = 1'b0;
    lmr_bad   = !(a[6:4] == 3'b010 || a[6:4] == 3'b011) ||
                (a[2:0] inside {3'b100, 3'b101, 3'b110});
    if (istate != READY) begin
      if (cmd != C_NOP && cmd != 3'b110) begin
        if ((istate == I_PCH && cmd == C_PCH && a[10]) ||
            ((istate == I_RF1 || istate == I_RF2) && cmd == C_AREF) ||
            (istate == I_LMR && cmd == C_LMR)) begin
          adv_init = 1'b1;
          do_aref  = (cmd == C_AREF);
          do_lmr   = (cmd == C_LMR);
          if (do_lmr && lmr_bad) begin err_hit = 1'b1; err_val = 3'd5; end
        end else begin
          err_hit = 1'b1;
          err_val = 3'd4;
        end
      end
    end else begin
      case (cmd)
        C_ACT: if (bank_open[ba]) begin err_hit = 1'b1; err_val = 3'd1; end
               else do_act = 1'b1;
        C_RD, C_WR: if (!bank_open[ba]) begin err_hit = 1'b1; err_val = 3'd2; end
                    else new_burst = 1'b1;
        C_PCH: do_pch = 1'b1;
        C_AREF: begin
          do_aref = 1'b1;
          if (|bank_open) begin err_hit = 1'b1; err_val = 3'd3; end
        end
        C_LMR: begin
          do_lmr = 1'b1;
          if (|bank_open) begin err_hit = 1'b1; err_val = 3'd6; end
          else if (lmr_bad) begin err_hit = 1'b1; err_val = 3'd5; end
        end
        default: ;
      endcase
    end
    pch_hit = do_pch && bst_act && (a[10] || ba == bst_bank);
  end

  // A freshly accepted RD/WR supplies beat 0 straight from the pins; later beats come from the burst registers.
  always_comb begin
    beat_vld  = 1'b0;
    beat_wr   = bst_wr;
    beat_bank = bst_bank;
    beat_row  = bst_row;
    beat_base = bst_col;
    beat_mask = bst_mask;
    beat_idx  = bst_cnt;
    beat_il   = bst_il;
    beat_ap   = bst_ap;
    if (new_burst) begin
      beat_vld  = 1'b1;
      beat_wr   = (cmd == C_WR);
      beat_bank = ba;
      beat_row  = bank_row[ba];
      beat_base = a[col_size-1:0];
      beat_mask = (cmd == C_WR && mode_wb) ? '0 : mode_mask;
      beat_idx  = '0;
      beat_il   = mode_bt;
      beat_ap   = cmd_ap;
    end else if (bst_act) begin
      beat_vld = 1'b1;
    end
    beat_last = (beat_idx == beat_mask);
    beat_c    = beat_col(beat_base, beat_mask, beat_idx, beat_il);
    beat_addr = {beat_bank, beat_row, beat_c};
  end

  always_comb begin
    out_due  = 1'b0;
    out_word = rd_dat_p1;
    if (rd_vld_p0 && !rd_cl3_p0) begin
      out_due  = 1'b1;
      out_word = rd_dat_p0;
    end else if (rd_vld_p1) begin
      out_due = 1'b1;
    end
    out_oe = out_due ? ~dqm_p0 : 2'b00;
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) begin
      istate    <= I_PCH;
      init_done <= 1'b0;
      proto_err <= 1'b0;
      err_code  <= 3'd0;
      aref_cnt  <= 8'd0;
      mode_cl3  <= 1'b0;
      mode_bt   <= 1'b0;
      mode_wb   <= 1'b0;
      mode_mask <= col_size'(1);
      bank_open <= '0;
      bst_act   <= 1'b0;
      rd_vld_p0 <= 1'b0;
      rd_cl3_p0 <= 1'b0;
      rd_vld_p1 <= 1'b0;
      dq_o      <= 16'h0000;
      dq_oe_o   <= 2'b00;
    end else begin
      proto_err <= err_hit;
      if (err_hit) err_code <= err_val;
      if (adv_init) begin
        case (istate)
          I_PCH:   istate <= I_RF1;
          I_RF1:   istate <= I_RF2;
          I_RF2:   istate <= I_LMR;
          default: begin istate <= READY; init_done <= 1'b1; end
        endcase
      end
      if (do_aref) aref_cnt <= aref_cnt + 8'd1;
      if (do_lmr) begin
        mode_wb   <= a[9];
        mode_cl3  <= (a[6:4] == 3'b011);
        mode_bt   <= a[3];
        mode_mask <= bl_mask(a[2:0]);
      end
      if (do_act) bank_open[ba] <= 1'b1;
      if (do_pch) begin
        if (a[10]) bank_open <= '0;
        else       bank_open[ba] <= 1'b0;
      end
      if (beat_vld && beat_last && beat_ap) bank_open[beat_bank] <= 1'b0;
      if (new_burst)    bst_act <= (beat_mask != '0);
      else if (bst_act) bst_act <= !(beat_last || pch_hit);
      // p0: word fetched for the beat issued this cycle
      rd_vld_p0 <= beat_vld && !beat_wr;
      rd_cl3_p0 <= mode_cl3;
      // p1: extra delay slot for CL=3
      rd_vld_p1 <= rd_vld_p0 && rd_cl3_p0;
      // output: dqm from two cycles back gates each byte
      dq_oe_o <= out_oe;
      dq_o    <= {out_oe[1] ? out_word[15:8] : 8'h00, out_oe[0] ? out_word[7:0] : 8'h00};
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (beat_vld && beat_wr) begin
      if (!dqm[0]) mem[beat_addr][7:0]  <= dq_i[7:0];
      if (!dqm[1]) mem[beat_addr][15:8] <= dq_i[15:8];
    end
    rd_dat_p0 <= mem[beat_addr];
    rd_dat_p1 <= rd_dat_p0;
    dqm_p0    <= dqm;
    if (do_act) bank_row[ba] <= a[mem_row_bits-1:0];
    if (new_burst) begin
      bst_wr   <= beat_wr;
      bst_bank <= beat_bank;
      bst_row  <= beat_row;
      bst_col  <= beat_base;
      bst_mask <= beat_mask;
      bst_il   <= beat_il;
      bst_ap   <= beat_ap;
      bst_cnt  <= col_size'(1);
    end else if (bst_act) begin
      bst_cnt <= bst_cnt + col_size'(1);
    end
  end

endmodule
